// File: rtl/board_clk_rst_ctrl_if.sv
// Board-side signal bundle of the clock/reset front end.
// Raw button/switch in; divided clock, SoC reset, fetch enable and debug state out.
interface board_clk_rst_ctrl_if;
    logic       rst_btn_n_i;
    logic       fetch_sw_i;
    logic       usr_clk_o;
    logic       usr_clk_rise_o;
    logic       soc_rst_n_o;
    logic       fetch_enable_o;
    logic [1:0] state_o;

    modport master (
        input  rst_btn_n_i,
        input  fetch_sw_i,
        output usr_clk_o,
        output usr_clk_rise_o,
        output soc_rst_n_o,
        output fetch_enable_o,
        output state_o
    );

    modport slave (
        output rst_btn_n_i,
        output fetch_sw_i,
        input  usr_clk_o,
        input  usr_clk_rise_o,
        input  soc_rst_n_o,
        input  fetch_enable_o,
        input  state_o
    );
endinterface

// File: rtl/board_clk_rst_ctrl.sv
// Board clock/reset front end: sync+debounce of button/switch, clock divider,
// stretched SoC reset released on a usr_clk fall, delayed fetch enable.
// Ports: clk, rst_n (sync, active low), bus (board_clk_rst_ctrl_if.master).
module board_clk_rst_ctrl #(
    parameter int DIV_HALF        = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RST_STRETCH     = 16,
    parameter int FETCH_DELAY     = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    board_clk_rst_ctrl_if.master        bus
);

    typedef enum logic [1:0] {
        HOLD       = 2'd0,
        STRETCH    = 2'd1,
        WAIT_FETCH = 2'd2,
        RUN        = 2'd3
    } state_t;

    localparam int VW   = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
    localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int EMAX = (RST_STRETCH > FETCH_DELAY) ? RST_STRETCH : FETCH_DELAY;
    localparam int EW   = $clog2(EMAX + 1);

    localparam logic [VW-1:0] DIV_LAST = VW'(DIV_HALF - 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [EW-1:0] STR_N    = EW'(RST_STRETCH);
    localparam logic [EW-1:0] FET_N    = EW'(FETCH_DELAY);

    logic          btn_s1, btn_s2, sw_s1, sw_s2;
    logic [DW-1:0] btn_cnt_q, btn_cnt_d, sw_cnt_q, sw_cnt_d;
    logic          btn_db_q, btn_db_d, sw_db_q, sw_db_d;
    logic [VW-1:0] div_q;
    logic          usr_clk_q, rise_q;
    logic          tick, rise_evt, fall_evt;
    state_t        state_q, state_d;
    logic [EW-1:0] ecnt_q, ecnt_d;
    logic          soc_rst_q, soc_rst_d;
    logic          fen_q, fen_d;

    // Debouncers: accept a new level after DEBOUNCE_CYCLES differing cycles.
    always_comb begin
        btn_cnt_d = btn_cnt_q;
        btn_db_d  = btn_db_q;
        if (btn_s2 == btn_db_q) begin
            btn_cnt_d = '0;
        end else if (btn_cnt_q == DB_LAST) begin
            btn_db_d  = btn_s2;
            btn_cnt_d = '0;
        end else begin
            btn_cnt_d = btn_cnt_q + DW'(1);
        end
    end

    always_comb begin
        sw_cnt_d = sw_cnt_q;
        sw_db_d  = sw_db_q;
        if (sw_s2 == sw_db_q) begin
            sw_cnt_d = '0;
        end else if (sw_cnt_q == DB_LAST) begin
            sw_db_d  = sw_s2;
            sw_cnt_d = '0;
        end else begin
            sw_cnt_d = sw_cnt_q + DW'(1);
        end
    end

    assign tick     = (div_q == DIV_LAST);
    assign rise_evt = tick & ~usr_clk_q;
    assign fall_evt = tick & usr_clk_q;

    // The FSM looks at the debouncer's next value so a button change acts
    // in the same cycle it is accepted.
    always_comb begin
        state_d   = state_q;
        ecnt_d    = ecnt_q;
        soc_rst_d = soc_rst_q;
        fen_d     = fen_q;
        unique case (state_q)
            HOLD: begin
                soc_rst_d = 1'b0;
                fen_d     = 1'b0;
                if (btn_db_d) begin
                    state_d = STRETCH;
                    ecnt_d  = '0;
                end
            end
            STRETCH: begin
                if (fall_evt && ecnt_q >= STR_N) begin
                    state_d   = WAIT_FETCH;
                    soc_rst_d = 1'b1;
                    ecnt_d    = '0;
                end else if (rise_evt && ecnt_q != '1) begin
                    ecnt_d = ecnt_q + EW'(1);
                end
            end
            WAIT_FETCH: begin
                if (fall_evt && ecnt_q >= FET_N) begin
                    state_d = RUN;
                end else if (rise_evt && ecnt_q != '1) begin
                    ecnt_d = ecnt_q + EW'(1);
                end
            end
            RUN: begin
                fen_d = sw_db_q;
            end
        endcase
        if (!btn_db_d) begin
            state_d   = HOLD;
            soc_rst_d = 1'b0;
            fen_d     = 1'b0;
            ecnt_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_s1    <= 1'b0;
            btn_s2    <= 1'b0;
            sw_s1     <= 1'b0;
            sw_s2     <= 1'b0;
            btn_cnt_q <= '0;
            sw_cnt_q  <= '0;
            btn_db_q  <= 1'b0;
            sw_db_q   <= 1'b0;
            div_q     <= '0;
            usr_clk_q <= 1'b0;
            rise_q    <= 1'b0;
            state_q   <= HOLD;
            ecnt_q    <= '0;
            soc_rst_q <= 1'b0;
            fen_q     <= 1'b0;
        end else begin
            btn_s1    <= bus.rst_btn_n_i;
            btn_s2    <= btn_s1;
            sw_s1     <= bus.fetch_sw_i;
            sw_s2     <= sw_s1;
            btn_cnt_q <= btn_cnt_d;
            sw_cnt_q  <= sw_cnt_d;
            btn_db_q  <= btn_db_d;
            sw_db_q   <= sw_db_d;
            div_q     <= tick ? '0 : div_q + VW'(1);
            usr_clk_q <= usr_clk_q ^ tick;
            rise_q    <= rise_evt;
            state_q   <= state_d;
            ecnt_q    <= ecnt_d;
            soc_rst_q <= soc_rst_d;
            fen_q     <= fen_d;
        end
    end

    assign bus.usr_clk_o      = usr_clk_q;
    assign bus.usr_clk_rise_o = rise_q;
    assign bus.soc_rst_n_o    = soc_rst_q;
    assign bus.fetch_enable_o = fen_q;
    assign bus.state_o        = state_q;

endmodule

// File: doc/board_clk_rst_ctrl.md
Name: board_clk_rst_ctrl

Overview:
- Board-level clock/reset front end that sits directly upstream of the FPGA SoC wrapper.
- Synchronises and debounces the raw reset button and fetch switch.
- Generates the divided SoC clock and a stretched SoC reset whose deassertion is aligned to that clock.
- Gates fetch-enable until a programmable number of SoC clock edges after reset release.

Parameters:
- DIV_HALF, 2: clk cycles per half-period of usr_clk_o (divide ratio 2*DIV_HALF; 50 MHz -> 12.5 MHz). Must be >= 1.
- DEBOUNCE_CYCLES, 500000: consecutive stable clk cycles needed to accept a new button/switch level. Must be >= 1.
- RST_STRETCH, 16: usr_clk_o rising edges during which SoC reset is held after button release. Must be >= 1.
- FETCH_DELAY, 8: usr_clk_o rising edges between SoC reset release and fetch-enable pass-through. Must be >= 1.

Ports:
- clk  in  1  board oscillator clock; all flops use the rising edge.
- rst_n  in  1  synchronous active-low reset (e.g. PLL locked).
- rst_btn_n_i  in  1  raw asynchronous reset button, low = pressed.
- fetch_sw_i  in  1  raw asynchronous fetch-enable switch, high = enable.
- usr_clk_o  out  1  divided SoC clock.
- usr_clk_rise_o  out  1  one-clk strobe, high in the cycle usr_clk_o becomes 1.
- soc_rst_n_o  out  1  active-low SoC reset.
- fetch_enable_o  out  1  SoC fetch enable.
- state_o  out  2  FSM state, for debug/LED.

Behaviour:
- Reset: rst_n low at a clk edge gives the following values: usr_clk_o=0, divider count=0, usr_clk_rise_o=0, soc_rst_n_o=0, fetch_enable_o=0, state=HOLD, edge counter=0.
- Reset values of the input paths: both synchronisers and the button debounced value reset to 0 (pressed). fetch_sw synchroniser and debounced value reset to 0.
- Reset mid-operation aborts everything to these values at the next edge.
- Synchroniser: 2 flops per raw input.
- Debouncer, per input: counter clears whenever the synced value equals the debounced value. Otherwise it increments. On the DEBOUNCE_CYCLES-th consecutive differing cycle, debounced value takes the synced value and the counter clears. A glitch shorter than DEBOUNCE_CYCLES is ignored. Latency from raw input to debounced value = 2 + DEBOUNCE_CYCLES clk.
- Divider: count runs 0..DIV_HALF-1. At DIV_HALF-1, usr_clk_o toggles and count returns to 0. It free-runs in every state.
  - rise = toggle while usr_clk_o==0.
  - fall = toggle while usr_clk_o==1.
  - usr_clk_rise_o is registered with the 0->1 toggle.
- FSM, encoding HOLD=0, STRETCH=1, WAIT_FETCH=2, RUN=3:
  - HOLD: soc_rst_n_o=0, fetch_enable_o=0. When debounced button = released (1): go to STRETCH and clear the edge counter.
  - STRETCH: edge counter increments on each rise. Once it has reached RST_STRETCH, the next fall causes, in the same cycle, state <= WAIT_FETCH, soc_rst_n_o <= 1, and edge counter cleared. Reset deassertion is therefore always on a usr_clk_o falling edge.
  - WAIT_FETCH: edge counter increments on each rise. Once it has reached FETCH_DELAY, the next fall causes state <= RUN.
  - RUN: fetch_enable_o <= debounced fetch_sw, registered every clk cycle.
  - Any state: debounced button = pressed (0) causes, at the next clk, state <= HOLD, soc_rst_n_o <= 0, fetch_enable_o <= 0, edge counter cleared. Assertion is not aligned to usr_clk_o. Press takes priority over any simultaneous transition.
- Edge counter width: $clog2(max(RST_STRETCH, FETCH_DELAY)+1). It saturates and does not wrap.
- state_o reflects the registered state.
- fetch_enable_o is 0 in every state except RUN.

Test Plan (bench parameters: DIV_HALF=2, DEBOUNCE_CYCLES=4, RST_STRETCH=3, FETCH_DELAY=2):
- Divider: hold rst_n=0 for 3 clk, then release -> usr_clk_o period 4 clk, 50% duty; first 0->1 at 2nd clk edge after release; usr_clk_rise_o one clk wide, coincident with each 0->1.
- Power-up sequence: release button (rst_btn_n_i=1) with fetch_sw_i=1.
  - State reaches STRETCH 6 clk after release (2 sync + 4 debounce).
  - soc_rst_n_o rises on the first fall after the 3rd rise in STRETCH.
  - RUN is entered on the first fall after the 2nd rise in WAIT_FETCH.
  - fetch_enable_o=1 one clk later.
- Glitch rejection: in RUN, pulse rst_btn_n_i low for 3 clk -> no state change. Pulse low for 4 clk -> HOLD, soc_rst_n_o=0 exactly 6 clk after the falling input.
- Abort mid-stretch: press button (held) during STRETCH after 1 rise -> HOLD; on re-release, the full 3-rise stretch restarts from 0.
- Fetch switch: in RUN toggle fetch_sw_i 1->0 -> fetch_enable_o falls 7 clk later (2 sync + 4 debounce + 1 register); 2-clk spike ignored.
- Synchronous reset mid-RUN: rst_n=0 for 1 clk -> all outputs at reset values the following cycle; with button held released, the sequence restarts via HOLD -> STRETCH after 6 clk.
